// File: rtl/mul_share_ctrl.sv
// Arbitrated controller that lets two requesters share one repeated-addition multiplier
// datapath. The datapath does the arithmetic; this block sequences it and captures the product.
module mul_share_ctrl #(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  input  logic           zf,
  input  logic [2*W-1:0] p_in,
  output logic [W-1:0]   bus,
  output logic           lda,
  output logic           ldb,
  output logic           ldp,
  output logic           clrp,
  output logic           decb,
  output logic [1:0]     gnt,
  output logic [1:0]     done,
  output logic [2*W-1:0] result,
  output logic           busy
);

  typedef enum logic [2:0] {StIdle, StLda, StLdb, StAcc, StDone} state_e;

  state_e         state_q, state_d;
  logic           rr_q, rr_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] result_q, result_d;
  logic           win;

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    win      = 1'b0;
    bus      = '0;
    lda      = 1'b0;
    ldb      = 1'b0;
    ldp      = 1'b0;
    clrp     = 1'b0;
    decb     = 1'b0;
    done     = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          // Round-robin pointer only matters on a tie.
          win     = (req == 2'b11) ? rr_q : req[1];
          gnt_d   = win ? 2'b10 : 2'b01;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          state_d = StLda;
        end
      end
      StLda: begin
        lda     = 1'b1;
        bus     = a_q;
        state_d = StLdb;
      end
      StLdb: begin
        ldb     = 1'b1;
        clrp    = 1'b1;
        bus     = b_q;
        state_d = StAcc;
      end
      StAcc: begin
        if (zf) begin
          result_d = p_in;
          state_d  = StDone;
        end else begin
          ldp  = 1'b1;
          decb = 1'b1;
        end
      end
      StDone: begin
        done    = gnt_q;
        // Point at the requester that was not just served.
        rr_d    = ~gnt_q[1];
        gnt_d   = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_q     <= 1'b0;
      gnt_q    <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gnt_q    <= gnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign gnt    = gnt_q;
  assign result = result_q;
  assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Bench for mul_share_ctrl: repeated-addition datapath model, directed scenarios and
// randomized requests checked against a product / latency / round-robin reference.
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] a0, b0, a1, b1;
  logic        zf;
  logic [31:0] p_in;
  logic [15:0] bus;
  logic        lda, ldb, ldp, clrp, decb;
  logic [1:0]  gnt, done;
  logic [31:0] result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m    = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.W(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .zf(zf), .p_in(p_in), .bus(bus),
    .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb),
    .gnt(gnt), .done(done), .result(result), .busy(busy)
  );

  // Repeated-addition datapath
  logic [15:0] dp_a = '0;
  logic [15:0] dp_b = '0;
  logic [31:0] dp_p = '0;
  always @(posedge clk) begin
    if (lda) dp_a <= bus;
    if (ldb) dp_b <= bus;
    else if (decb) dp_b <= dp_b - 16'd1;
    if (clrp) dp_p <= '0;
    else if (ldp) dp_p <= dp_p + {16'd0, dp_a};
  end
  assign zf   = (dp_b == 16'd0);
  assign p_in = dp_p;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant/done exclusivity and idle bus, every cycle
  always @(negedge clk) begin
    if (mon_en) begin
      check_val("onehot", {29'd0, $onehot0(gnt), $onehot0(done), ((done & ~gnt) == 2'b00)},
                32'd7);
      if (!lda && !ldb) check_val("bus_idle", {16'd0, bus}, 32'd0);
    end
  end

  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b11) return rr_m;
    return r[1] ? 1 : 0;
  endfunction

  // One complete operation starting with the grant edge; req must be set and state IDLE.
  task automatic run_op(input bit drop_mid, input bit chg_mid, input logic [15:0] new_a,
                        input bit keep);
    int          r;
    int          ncyc;
    int          nldp;
    int          ndecb;
    bit          seen;
    logic [15:0] ea, eb;
    logic [31:0] prod;
    logic [1:0]  g_exp;
    r     = model_pick(req);
    ea    = r ? a1 : a0;
    eb    = r ? b1 : b0;
    prod  = 32'(ea) * 32'(eb);
    g_exp = (r == 1) ? 2'b10 : 2'b01;
    tick();
    check_val("gnt_c1", {30'd0, gnt}, {30'd0, g_exp});
    check_val("lda_c1", {27'd0, lda, ldb, ldp, clrp, decb}, 32'b10000);
    check_val("bus_a", {16'd0, bus}, {16'd0, ea});
    if (chg_mid) begin
      if (r == 1) a1 = new_a;
      else a0 = new_a;
    end
    if (drop_mid) req[r] = 1'b0;
    tick();
    check_val("ldb_c2", {27'd0, lda, ldb, ldp, clrp, decb}, 32'b01010);
    check_val("bus_b", {16'd0, bus}, {16'd0, eb});
    ncyc  = 2;
    nldp  = 0;
    ndecb = 0;
    seen  = 1'b0;
    while (!seen && ncyc < int'(eb) + 12) begin
      tick();
      ncyc++;
      if (ldp) nldp++;
      if (decb) ndecb++;
      if (done != 2'b00) seen = 1'b1;
    end
    check_val("done_seen", {31'd0, seen}, 32'd1);
    check_val("done_cyc", ncyc, int'(eb) + 4);
    check_val("done_val", {30'd0, done}, {30'd0, g_exp});
    check_val("gnt_done", {30'd0, gnt}, {30'd0, g_exp});
    check_val("result", result, prod);
    check_val("ldp_cnt", nldp, int'(eb));
    check_val("decb_cnt", ndecb, int'(eb));
    rr_m = 1 - r;
    if (!keep) req[r] = 1'b0;
    tick();
    check_val("idle_after", {29'd0, busy, gnt}, 32'd0);
    check_val("done_once", {30'd0, done}, 32'd0);
    check_val("result_hold", result, prod);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    tick();
    check_val("rst_out", {25'd0, busy, gnt, done, lda, ldb}, 32'd0);
    check_val("rst_strb", {29'd0, ldp, clrp, decb}, 32'd0);
    check_val("rst_bus", {16'd0, bus}, 32'd0);
    check_val("rst_res", result, 32'd0);
    rst    = 1'b0;
    rr_m   = 0;
    mon_en = 1'b1;
    tick();
    check_val("idle_noreq", {29'd0, busy, gnt}, 32'd0);

    // Contention, both held: 0, then 1, then 0 again
    a0 = 16'd2; b0 = 16'd2; a1 = 16'd5; b1 = 16'd1;
    req = 2'b11;
    check_val("arb_first", model_pick(req), 0);
    run_op(1'b0, 1'b0, '0, 1'b1);
    check_val("arb_second", model_pick(req), 1);
    run_op(1'b0, 1'b0, '0, 1'b1);
    check_val("arb_third", model_pick(req), 0);
    run_op(1'b0, 1'b0, '0, 1'b0);
    req = 2'b00;
    tick();

    // Single request 7*3
    a0 = 16'd7; b0 = 16'd3; req = 2'b01;
    run_op(1'b0, 1'b0, '0, 1'b0);

    // Zero B operand
    a1 = 16'd9; b1 = 16'd0; req = 2'b10;
    run_op(1'b0, 1'b0, '0, 1'b0);

    // Zero A operand, nonzero B
    a0 = 16'd0; b0 = 16'd6; req = 2'b01;
    run_op(1'b0, 1'b0, '0, 1'b0);

    // Operand change and req drop after grant
    a0 = 16'd3; b0 = 16'd4; req = 2'b01;
    run_op(1'b1, 1'b1, 16'd100, 1'b0);

    // Max A
    a0 = 16'hFFFF; b0 = 16'd5; req = 2'b01;
    run_op(1'b0, 1'b0, '0, 1'b0);

    // Reset during requester 1's ACC
    a1 = 16'd4; b1 = 16'd5; req = 2'b10;
    tick();
    tick();
    tick();
    tick();
    check_val("in_acc", {27'd0, busy, gnt, ldp, decb}, 32'b11011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b00;
    rr_m = 0;
    check_val("rst_acc", {27'd0, busy, gnt, done}, 32'd0);
    check_val("rst_acc_res", result, 32'd0);
    tick();
    check_val("rst_acc_nodone", {27'd0, busy, gnt, done}, 32'd0);

    // Randomized traffic; pending requesters stay pending
    for (int i = 0; i < 25; i++) begin
      logic [1:0] nr;
      logic       drop, chg;
      nr = 2'($urandom_range(0, 3));
      if (!req[0] && nr[0]) begin a0 = 16'($urandom()); b0 = 16'($urandom_range(0, 12)); end
      if (!req[1] && nr[1]) begin a1 = 16'($urandom()); b1 = 16'($urandom_range(0, 12)); end
      req = req | nr;
      if (req == 2'b00) begin
        a0 = 16'($urandom()); b0 = 16'($urandom_range(0, 12)); req = 2'b01;
      end
      drop = ($urandom_range(0, 3) == 0);
      chg  = ($urandom_range(0, 3) == 0);
      run_op(drop, chg, 16'($urandom()), 1'b0);
    end

    req = 2'b00;
    tick();
    tick();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
